// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Instruction fetch stage sitting between the program counter and decode.
//   Each accepted PC address is issued to a synchronous ROM; the returned
//   word is captured one edge later together with its address into a small
//   circular buffer that decode drains with a valid/ready handshake.
//   All state advances on the falling edge of clk; rst is synchronous and
//   active-high.
//
//   Optional feature (compile-time macro FETCH_BYPASS_EN):
//     When the buffer is empty, a word returning from the ROM is presented
//     to decode combinationally in the same cycle. If decode takes it, the
//     word is never written into the buffer.
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     pc_valid,
    output logic                     pc_hold,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [INSTR_W-1:0]       rom_data,
    input  logic                     flush,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Buffered entries: instruction word and the address it was fetched from.
    logic [INSTR_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_inflight_v;
    logic [ADDR_W-1:0]  r_inflight_pc;

    logic [CNT_W-1:0]   w_credit;
    logic               w_buf_valid;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;

    // Credits include the read still in flight, so a word already requested
    // from the ROM always has a slot waiting for it. Only registered state
    // feeds this, which keeps pc_hold free of paths from instr_ready.
    assign w_credit = r_count + CNT_W'(r_inflight_v);
    assign pc_hold  = (w_credit >= CNT_W'(DEPTH));
    assign rom_en   = pc_valid & ~pc_hold & ~flush & ~rst;
    assign rom_addr = pc;
    assign count    = r_count;

    // Push/pop decisions, optional bypass, and the head-of-buffer view.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_buf_valid = (r_count != '0);
`ifdef FETCH_BYPASS_EN
        w_bypass    = ~w_buf_valid & r_inflight_v & ~flush;
`else
        w_bypass    = 1'b0;
`endif
        w_pop       = w_buf_valid & instr_ready & ~flush;
        w_push      = r_inflight_v & ~flush & ~(w_bypass & instr_ready);
        instr_valid = w_buf_valid | w_bypass;
        instr       = '0;
        instr_pc    = '0;
        if (w_bypass) begin
            instr    = rom_data;
            instr_pc = r_inflight_pc;
        end else if (w_buf_valid) begin
            instr    = r_mem_data[r_rd_ptr];
            instr_pc = r_mem_pc[r_rd_ptr];
        end
    end

    // Write the returning ROM word and its address into the slot at wr_ptr.
    always_ff @(negedge clk) begin
        // NOTE: the storage array carries no reset; count and the pointers
        // decide what is visible, so stale contents are never observed.
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= rom_data;
            r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

    // Pointers, occupancy and the in-flight read tracker.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
        end else if (flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= pc;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_inflight_v  <= rom_en;
            r_inflight_pc <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//   Self-checking bench for fetch_buffer. A queue-based reference model
//   tracks what decode must see; a compare process checks the DUT against
//   it every cycle, and directed sections pin key values by hand.
//   Build with +define+FETCH_BYPASS_EN to exercise the bypass variant.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [ADDR_W-1:0]      pc;
    logic                   pc_valid;
    logic                   pc_hold;
    logic                   rom_en;
    logic [ADDR_W-1:0]      rom_addr;
    logic [INSTR_W-1:0]     rom_data;
    logic                   flush;
    logic [INSTR_W-1:0]     instr;
    logic [ADDR_W-1:0]      instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [$clog2(DEPTH):0] count;

    fetch_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_hold(pc_hold),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .flush(flush), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int cyc_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Synchronous ROM: word = 0x1000 + address. When not read, the bus
    // carries junk (0xBEEF) so a stray push is visible.
    logic [INSTR_W-1:0] rom_mem [64];
    initial for (int a = 0; a < 64; a++) rom_mem[a] = 16'h1000 + 16'(a);
    always @(negedge clk) rom_data <= rom_en ? rom_mem[rom_addr] : 16'hBEEF;

    // Reference model: buffered words as a queue, plus the pending read.
    logic [INSTR_W-1:0] mq_data [$];
    logic [ADDR_W-1:0]  mq_pc   [$];
    bit                 pend_v = 1'b0;
    logic [ADDR_W-1:0]  pend_pc = '0;

    always @(negedge clk) begin
        bit hold, en, take;
        hold = (mq_data.size() + int'(pend_v)) >= DEPTH;
        en   = pc_valid && !hold && !flush && !rst;
        if (rst || flush) begin
            mq_data.delete();
            mq_pc.delete();
        end else begin
            take = BYP && mq_data.size() == 0 && pend_v && instr_ready;
            if (mq_data.size() != 0 && instr_ready) begin
                void'(mq_data.pop_front());
                void'(mq_pc.pop_front());
            end
            if (pend_v && !take) begin
                mq_data.push_back(rom_mem[pend_pc]);
                mq_pc.push_back(pend_pc);
            end
        end
        pend_v  = en;
        pend_pc = pc;
    end

    // Handshake log for order checks in the directed sections.
    logic [INSTR_W-1:0] log_data [$];
    logic [ADDR_W-1:0]  log_pc   [$];
    int                 log_cyc  [$];

    // Compare process: checks every DUT output against the model mid-cycle.
    always @(posedge clk) begin
        bit e_hold, e_en, e_byp, e_valid;
        cyc_n++;
        if (chk_en) begin
            e_hold  = (mq_data.size() + int'(pend_v)) >= DEPTH;
            e_en    = pc_valid && !e_hold && !flush && !rst;
            e_byp   = BYP && mq_data.size() == 0 && pend_v && !flush;
            e_valid = (mq_data.size() != 0) || e_byp;
            check("count",       32'(count),       32'(mq_data.size()));
            check("pc_hold",     32'(pc_hold),     32'(e_hold));
            check("rom_en",      32'(rom_en),      32'(e_en));
            check("rom_addr",    32'(rom_addr),    32'(pc));
            check("instr_valid", 32'(instr_valid), 32'(e_valid));
            if (e_valid && mq_data.size() != 0) begin
                check("instr",    32'(instr),    32'(mq_data[0]));
                check("instr_pc", 32'(instr_pc), 32'(mq_pc[0]));
            end else if (e_valid) begin
                check("bypass instr",    32'(instr),    32'(rom_mem[pend_pc]));
                check("bypass instr_pc", 32'(instr_pc), 32'(pend_pc));
            end
            if (instr_valid && instr_ready && !flush && !rst) begin
                log_data.push_back(instr);
                log_pc.push_back(instr_pc);
                log_cyc.push_back(cyc_n);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        pc_valid    = 1'b0;
        instr_ready = 1'b1;
        budget      = 0;
        while ((count != 0 || instr_valid) && budget < 12) begin
            step();
            budget++;
        end
        if (budget >= 12) check("drain timeout", 32'(0), 32'(1));
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        int  issued, budget;
        bit  en_now, tog;

        rst = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        step();
        chk_en = 1'b1;
        check("reset count",       32'(count),       32'(0));
        check("reset instr_valid", 32'(instr_valid), 32'(0));
        check("reset pc_hold",     32'(pc_hold),     32'(0));
        rst = 1'b0;

        // Reset mid-stream: three buffered plus one in flight, then reset.
        pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = ADDR_W'(i);
            step();
        end
        check("prefill count", 32'(count), 32'(3));
        rst = 1'b1;
        step();
        rst = 1'b0; pc_valid = 1'b0;
        check("midrst count",       32'(count),       32'(0));
        check("midrst instr_valid", 32'(instr_valid), 32'(0));
        check("midrst pc_hold",     32'(pc_hold),     32'(0));
        for (int i = 0; i < 3; i++) step();
        check("stale word count",       32'(count),       32'(0));
        check("stale word instr_valid", 32'(instr_valid), 32'(0));

        // Streaming 0..7 with decode always ready.
        log_data.delete(); log_pc.delete(); log_cyc.delete();
        instr_ready = 1'b1; pc_valid = 1'b1; issued = 0; budget = 0;
        while (issued < 8 && budget < 40) begin
            pc = ADDR_W'(issued);
            #1 en_now = rom_en;
            step();
            budget++;
            if (en_now) begin
                issued++;
                if (issued == 1) check("stream valid after issue edge", 32'(instr_valid), 32'(BYP));
                if (issued == 2) check("stream valid one edge later",   32'(instr_valid), 32'(1));
            end
        end
        pc_valid = 1'b0; budget = 0;
        while (log_pc.size() < 8 && budget < 20) begin step(); budget++; end
        check("stream accepted", 32'(log_pc.size()), 32'(8));
        for (int i = 0; i < 8 && i < log_pc.size(); i++) begin
            check("stream instr",    32'(log_data[i]), 32'(16'h1000 + 16'(i)));
            check("stream instr_pc", 32'(log_pc[i]),   32'(i));
        end
        if (log_cyc.size() >= 8) check("stream no gaps", 32'(log_cyc[7] - log_cyc[0]), 32'(7));
        drain();

        // Full back-pressure then a single pop.
        instr_ready = 1'b0; pc_valid = 1'b1; pc = 6'h30;
        for (int i = 0; i < 6; i++) begin
            #1 en_now = rom_en;
            step();
            if (en_now) pc = pc + 6'd1;
        end
        check("full count",   32'(count),   32'(4));
        check("full pc_hold", 32'(pc_hold), 32'(1));
        check("full rom_en",  32'(rom_en),  32'(0));
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("after pop pc_hold", 32'(pc_hold), 32'(0));
        check("after pop count",   32'(count),   32'(3));
        drain();

        // Flush with two buffered and one read pending.
        pc_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            pc = ADDR_W'(i);
            step();
        end
        check("preflush count", 32'(count), 32'(2));
        flush = 1'b1; instr_ready = 1'b1;
        step();
        flush = 1'b0; instr_ready = 1'b0;
        check("flush count",       32'(count),       32'(0));
        check("flush instr_valid", 32'(instr_valid), 32'(0));
        pc = 6'h20;
        step();
        pc_valid = 1'b0;
        step();
        check("target valid",    32'(instr_valid), 32'(1));
        check("target instr_pc", 32'(instr_pc),    32'(6'h20));
        check("target instr",    32'(instr),       32'(16'h1020));
        drain();

        // Wrap with decode toggling ready.
        log_data.delete(); log_pc.delete(); log_cyc.delete();
        issued = 0; budget = 0; tog = 1'b1;
        while (log_pc.size() < 20 && budget < 200) begin
            instr_ready = tog;
            tog         = ~tog;
            pc_valid    = (issued < 20);
            pc          = ADDR_W'(10 + issued);
            #1 en_now = rom_en;
            step();
            budget++;
            if (en_now) issued++;
        end
        check("wrap accepted", 32'(log_pc.size()), 32'(20));
        for (int i = 0; i < 20 && i < log_pc.size(); i++) begin
            check("wrap instr_pc", 32'(log_pc[i]),   32'(10 + i));
            check("wrap instr",    32'(log_data[i]), 32'(16'h1000 + 16'(10 + i)));
        end
        drain();

        // Single fetch of pc=5 into an empty buffer with decode ready.
        pc = 6'd5; pc_valid = 1'b1; instr_ready = 1'b1;
        step();
        pc_valid = 1'b0;
`ifdef FETCH_BYPASS_EN
        check("bypass valid",    32'(instr_valid), 32'(1));
        check("bypass instr_pc", 32'(instr_pc),    32'(5));
        check("bypass instr",    32'(instr),       32'(16'h1005));
        check("bypass count",    32'(count),       32'(0));
        step();
        check("bypass count after", 32'(count),       32'(0));
        check("bypass valid after", 32'(instr_valid), 32'(0));
`else
        check("single valid after issue", 32'(instr_valid), 32'(0));
        step();
        check("single valid",    32'(instr_valid), 32'(1));
        check("single instr_pc", 32'(instr_pc),    32'(5));
        check("single count",    32'(count),       32'(1));
`endif
        drain();

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(99) == 0);
            flush       = ($urandom_range(24) == 0);
            pc_valid    = ($urandom_range(4) != 0);
            instr_ready = ($urandom_range(4) < 3);
            pc          = ADDR_W'($urandom_range(63));
            step();
        end
        rst = 1'b0; flush = 1'b0; pc_valid = 1'b0; instr_ready = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
